// File: rtl/hybridcache_pkg.sv
// hybridcache_pkg
//   Types and constants shared by the hybrid cache blocks.
//   fill_state_t       : line-fill FSM state (IDLE / REQ / DONE)
//   LWB_DEFAULT        : default log2 of words per cache line
//   WORD_OFF_BITS      : byte-offset bits inside one 32-bit word
//   line_off_bits()    : byte-offset bits inside one cache line
package hybridcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

  localparam int LWB_DEFAULT   = 2;
  localparam int WORD_OFF_BITS = 2;

  function automatic int line_off_bits(input int lwb);
    return lwb + WORD_OFF_BITS;
  endfunction

endpackage

// File: rtl/linefill_engine.sv
// linefill_engine
//   Pops one miss address from the miss queue, fetches the whole cache line
//   from memory as a burst of 2^LINEWORDBITS word beats, and writes each beat
//   into the line RAM as it arrives. Signals completion with a fill_done pulse.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   req_addr, req_valid   : head of the miss queue
//   req_pop               : one-cycle pop strobe to the miss queue
//   mem_rd, mem_addr      : memory read request / word-aligned beat address
//   mem_ack, mem_rdata    : beat acknowledge with same-cycle read data
//   fill_we/waddr/wdata   : line-RAM write port
//   fill_done             : one-cycle line-complete pulse
//   fill_line             : line base of the last completed or in-progress fill
//   busy                  : FSM is not idle
module linefill_engine
  import hybridcache_pkg::*;
#(
  parameter int ADDRBITS     = 32,
  parameter int DATABITS     = 32,
  parameter int LINEWORDBITS = LWB_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] req_addr,
  input  logic                req_valid,
  output logic                req_pop,
  output logic                mem_rd,
  output logic [ADDRBITS-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [DATABITS-1:0] mem_rdata,
  output logic                fill_we,
  output logic [ADDRBITS-1:0] fill_waddr,
  output logic [DATABITS-1:0] fill_wdata,
  output logic                fill_done,
  output logic [ADDRBITS-1:0] fill_line,
  output logic                busy
);

  localparam int OFFBITS = line_off_bits(LINEWORDBITS);
  localparam logic [ADDRBITS-1:0] LINE_MASK = ~(ADDRBITS'((1 << OFFBITS) - 1));
  localparam logic [LINEWORDBITS-1:0] LAST_BEAT = '1;

  fill_state_t             state;
  logic [LINEWORDBITS-1:0] beat;
  logic [ADDRBITS-1:0]     line_base;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      beat      <= '0;
      line_base <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            line_base <= req_addr & LINE_MASK;
            beat      <= '0;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // beat wraps back to 0 after the last beat, ready for the next line
          if (mem_ack) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs must react in the same cycle as req_valid / mem_ack, so
  // they are decoded from the state register rather than registered again.
  // req_pop is gated by reset: the async reset forces IDLE, and a pending
  // miss must not be popped while reset is held.
  assign req_pop    = (state == ST_IDLE) && req_valid && !reset;
  assign mem_rd     = (state == ST_REQ);
  assign busy       = (state != ST_IDLE);
  assign fill_done  = (state == ST_DONE);
  assign fill_we    = (state == ST_REQ) && mem_ack;

  // line_base has its offset bits cleared, so OR-ing the beat offset can
  // never carry into the line address.
  assign mem_addr   = line_base | ADDRBITS'({beat, {WORD_OFF_BITS{1'b0}}});
  assign fill_waddr = mem_addr;
  assign fill_wdata = mem_rdata;
  assign fill_line  = line_base;

endmodule

// File: tb/tb_linefill_engine.sv
// tb_linefill_engine
//   Randomized bench for linefill_engine. The reference model tracks a miss
//   queue, the list of beat addresses still owed for the open line, and a
//   hashed memory image; each cycle's outputs are predicted from those.
module tb_linefill_engine;

  logic        clk;
  logic        reset;
  logic [31:0] req_addr;
  logic        req_valid;
  logic        req_pop;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        fill_we;
  logic [31:0] fill_waddr;
  logic [31:0] fill_wdata;
  logic        fill_done;
  logic [31:0] fill_line;
  logic        busy;

  linefill_engine dut (
    .clk        (clk),
    .reset      (reset),
    .req_addr   (req_addr),
    .req_valid  (req_valid),
    .req_pop    (req_pop),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .fill_we    (fill_we),
    .fill_waddr (fill_waddr),
    .fill_wdata (fill_wdata),
    .fill_done  (fill_done),
    .fill_line  (fill_line),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // reference model state
  logic [31:0] missq[$];
  logic [31:0] owed[$];     // beat addresses still to be written for the open line
  logic [31:0] pop_cyc[$];
  logic [31:0] cur_base;
  bit          line_open;
  int          cyc;
  int          pop_at;
  int          ack_mode;    // 0: always ack, 1: 3 idle cycles per beat, 2: random
  int          stall_cnt;
  bit          gappy;       // randomly drop req_valid even with misses queued

  // One clock cycle: drive inputs at negedge, check outputs 1ns later.
  task automatic tick();
    bit exp_pop, exp_rd, exp_done;
    @(negedge clk);
    req_valid = (missq.size() > 0) && (!gappy || ($urandom_range(0, 3) != 0));
    req_addr  = (missq.size() > 0) ? missq[0] : $urandom;
    case (ack_mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = (stall_cnt >= 3);
      default: mem_ack = $urandom_range(0, 1) != 0;
    endcase
    if (!mem_ack) stall_cnt++;
    mem_rdata = mem_ack ? mem_word(mem_addr) : $urandom;
    #1;
    exp_pop  = !line_open && req_valid;
    exp_rd   = line_open && (owed.size() > 0);
    exp_done = line_open && (owed.size() == 0);
    chk("req_pop", req_pop, exp_pop);
    chk("busy", busy, line_open);
    chk("mem_rd", mem_rd, exp_rd);
    chk("fill_done", fill_done, exp_done);
    chk("fill_we", fill_we, exp_rd && mem_ack);
    if (exp_rd) chk("mem_addr", mem_addr, owed[0]);
    if (exp_rd && mem_ack) begin
      chk("fill_waddr", fill_waddr, owed[0]);
      chk("fill_wdata", fill_wdata, mem_word(owed[0]));
      void'(owed.pop_front());
      stall_cnt = 0;
    end
    if (exp_done) begin
      chk("fill_line", fill_line, cur_base);
      if (ack_mode == 0) chk("done_latency", 32'(cyc - pop_at), 32'd5);
      line_open = 1'b0;
    end
    if (exp_pop) begin
      cur_base = req_addr & ~32'hF;
      for (int k = 0; k < 4; k++) owed.push_back(cur_base + 32'(4 * k));
      void'(missq.pop_front());
      pop_cyc.push_back(32'(cyc));
      line_open = 1'b1;
      pop_at    = cyc;
      stall_cnt = 0;
    end
    cyc++;
  endtask

  task automatic run_until_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (!line_open && missq.size() == 0) return;
    end
    chk("timeout", 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pop"}, req_pop, 1'b0);
    chk({tag, "_rd"}, mem_rd, 1'b0);
    chk({tag, "_we"}, fill_we, 1'b0);
    chk({tag, "_done"}, fill_done, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_line"}, fill_line, 32'h0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_1234;
    mem_ack = 1'b1; mem_rdata = 32'h0;
    cyc = 0; line_open = 1'b0; ack_mode = 0; stall_cnt = 0; gappy = 1'b0;
    cur_base = 32'h0; pop_at = 0;

    // reset holds everything quiet even with a pending miss and an ack
    #13;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;

    // spurious acks while idle
    ack_mode = 0;
    for (int i = 0; i < 4; i++) tick();

    // single miss, ack every cycle
    missq.push_back(32'h0000_1234);
    run_until_idle(20);
    chk("line_1234", fill_line, 32'h0000_1230);

    // same miss, 3 stall cycles before each beat
    ack_mode = 1;
    missq.push_back(32'h0000_1234);
    run_until_idle(40);

    // two back-to-back misses, req_valid held high
    ack_mode = 0;
    pop_cyc.delete();
    missq.push_back(32'h0000_0100);
    missq.push_back(32'h0000_02F0);
    run_until_idle(30);
    chk("pop_count", 32'(pop_cyc.size()), 32'd2);
    if (pop_cyc.size() == 2) chk("pop_spacing", pop_cyc[1] - pop_cyc[0], 32'd6);
    chk("line_2f0", fill_line, 32'h0000_02F0);

    // reset after beat 2 of line 0x400
    missq.push_back(32'h0000_0400);
    for (int i = 0; i < 20 && !(line_open && owed.size() == 2); i++) tick();
    chk("reached_beat2", 32'(owed.size()), 32'd2);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; mem_ack = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    owed.delete(); line_open = 1'b0; cur_base = 32'h0;
    for (int i = 0; i < 3; i++) tick();   // no pop, no done, no writes
    missq.push_back(32'h0000_0800);
    run_until_idle(20);
    chk("line_800", fill_line, 32'h0000_0800);

    // random misses, random acks, gaps in req_valid
    ack_mode = 2;
    gappy = 1'b1;
    for (int i = 0; i < 20; i++) missq.push_back($urandom);
    run_until_idle(2000);
    gappy = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
